// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks.
//   - FSM state encoding for the stall/flush sequencer
//   - register-address width and the hardwired zero register
//   - memory-wait counter width
//   - ctrl_t: bundle of the per-cycle PC / pipeline-register enables and flushes
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  localparam int WAIT_W     = 8;
  // Holds LOAD_STALL_CYCLES-1, so 2 bits cover the 1..3 range.
  localparam int LOAD_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOADUSE = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_BAD     = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic exme_we;
    logic mewb_we;
  } ctrl_t;

  // Field order: pc_we ifid_we ifid_flush idex_flush exme_we mewb_we
  localparam ctrl_t CTRL_RUN    = 6'b110011; // everything advances
  localparam ctrl_t CTRL_RESET  = 6'b001100; // hold all, bubble IF/ID and ID/EX
  localparam ctrl_t CTRL_FREEZE = 6'b000000; // whole pipe stalled on DM
  localparam ctrl_t CTRL_STALL  = 6'b000111; // hold PC+IF/ID, bubble into EX
  localparam ctrl_t CTRL_BRANCH = 6'b111111; // redirect, squash IF and ID

  function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare.
// A load in EX writing a non-zero register that the ID instruction reads
// (rs always, rt only when used) cannot be forwarded in time.
//   IDRs, IDRt, IDUsesRt        : ID-stage source operands
//   EXMemRead, EXRegWrite,
//   EXWriteReg                  : EX-stage producer
//   Hazard                      : load-use hazard present this cycle
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] IDRs,
  input  logic [REG_ADDR_W-1:0] IDRt,
  input  logic                  IDUsesRt,
  input  logic                  EXMemRead,
  input  logic                  EXRegWrite,
  input  logic [REG_ADDR_W-1:0] EXWriteReg,
  output logic                  Hazard
);

  logic rs_hit, rt_hit;

  assign rs_hit = (EXWriteReg == IDRs);
  assign rt_hit = IDUsesRt & (EXWriteReg == IDRt);
  assign Hazard = EXMemRead & EXRegWrite & (EXWriteReg != ZERO_REG) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_stall_controller.sv
// Central stall/flush sequencer for the IF/ID/EX/ME/WB pipeline.
// Outputs are Mealy: decoded from registered state plus this cycle's inputs,
// so every event is acted on in the cycle it is presented.
//   Clk, Reset (sync, active high)
//   IDRs, IDRt, IDUsesRt, EXMemRead, EXRegWrite, EXWriteReg : load-use inputs
//   MEAccess, DMReady : data-memory handshake
//   BranchTaken       : EX redirect
//   PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEWrite, MEWBWrite : controls
//   State      : FSM state (debug)
//   StallCount : saturating count of cycles with PCWrite=0
//   MemError   : sticky DM timeout flag
module hazard_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255,
  parameter int CNT_W             = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] IDRs,
  input  logic [REG_ADDR_W-1:0] IDRt,
  input  logic                  IDUsesRt,
  input  logic                  EXMemRead,
  input  logic                  EXRegWrite,
  input  logic [REG_ADDR_W-1:0] EXWriteReg,
  input  logic                  MEAccess,
  input  logic                  DMReady,
  input  logic                  BranchTaken,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFIDFlush,
  output logic                  IDEXFlush,
  output logic                  EXMEWrite,
  output logic                  MEWBWrite,
  output logic [1:0]            State,
  output logic [CNT_W-1:0]      StallCount,
  output logic                  MemError
);

  localparam logic [LOAD_CNT_W-1:0] LOAD_CNT_INIT = LOAD_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [WAIT_W-1:0]     TIMEOUT_V     = WAIT_W'(MEM_TIMEOUT);

  state_e                state_q, state_d;
  state_e                ret_q, ret_d;
  state_e                eff;
  logic [LOAD_CNT_W-1:0] lcnt_q, lcnt_d;
  logic [WAIT_W-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]      scnt_q;
  logic                  merr_q, merr_d;
  logic                  lu, freeze, live;
  ctrl_t                 ctl;

  load_use_detect u_lud (
    .IDRs       (IDRs),
    .IDRt       (IDRt),
    .IDUsesRt   (IDUsesRt),
    .EXMemRead  (EXMemRead),
    .EXRegWrite (EXRegWrite),
    .EXWriteReg (EXWriteReg),
    .Hazard     (lu)
  );

  assign freeze = MEAccess & ~DMReady;

  always_comb begin
    ctl     = CTRL_RUN;
    state_d = state_q;
    ret_d   = ret_q;
    lcnt_d  = lcnt_q;
    wcnt_d  = wcnt_q;
    merr_d  = merr_q;
    eff     = state_q;
    live    = 1'b0;

    // First resolve the memory freeze; "live" means the pipe is free to move
    // this cycle and eff is the state whose branch/load-use rules apply.
    case (state_q)
      ST_RUN, ST_LOADUSE: begin
        if (freeze) begin
          ctl     = CTRL_FREEZE;
          ret_d   = state_q;
          wcnt_d  = WAIT_W'(1);
          state_d = ST_MEMWAIT;
        end else begin
          live = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (!DMReady) begin
          ctl    = CTRL_FREEZE;
          wcnt_d = sat_inc_wait(wcnt_q);
          if (wcnt_q == TIMEOUT_V) merr_d = 1'b1;
        end else begin
          // Release: behave as the interrupted state in the same cycle so the
          // completed access drains without an extra bubble.
          eff  = ret_q;
          live = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (live) begin
      if (BranchTaken) begin
        // ID holds a wrong-path instruction, so any load-use is moot.
        ctl     = CTRL_BRANCH;
        lcnt_d  = '0;
        state_d = ST_RUN;
      end else if (eff == ST_LOADUSE) begin
        ctl     = CTRL_STALL;
        lcnt_d  = (lcnt_q == '0) ? '0 : lcnt_q - 1'b1;
        state_d = (lcnt_q <= LOAD_CNT_W'(1)) ? ST_RUN : ST_LOADUSE;
      end else if (lu) begin
        ctl = CTRL_STALL;
        if (LOAD_STALL_CYCLES > 1) begin
          lcnt_d  = LOAD_CNT_INIT;
          state_d = ST_LOADUSE;
        end else begin
          state_d = ST_RUN;
        end
      end else begin
        state_d = ST_RUN;
      end
    end

    if (Reset) ctl = CTRL_RESET;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      lcnt_q  <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      lcnt_q  <= lcnt_d;
      wcnt_q  <= wcnt_d;
      merr_q  <= merr_d;
      if (!ctl.pc_we && (scnt_q != '1)) scnt_q <= scnt_q + 1'b1;
    end
  end

  assign PCWrite    = ctl.pc_we;
  assign IFIDWrite  = ctl.ifid_we;
  assign IFIDFlush  = ctl.ifid_flush;
  assign IDEXFlush  = ctl.idex_flush;
  assign EXMEWrite  = ctl.exme_we;
  assign MEWBWrite  = ctl.mewb_we;
  assign State      = state_q;
  assign StallCount = scnt_q;
  assign MemError   = merr_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: the stimulus process drives one directed vector per cycle
// and queues its hand-computed expected outputs; the monitor pops and compares
// on the falling edge. Two instances share all inputs:
//   dut  : LOAD_STALL_CYCLES=2, MEM_TIMEOUT=3 (fully checked)
//   dutb : default parameters (PCWrite and MemError checked)
module tb_hazard_stall_controller;

  typedef struct {
    logic       rst;
    logic       mrd, rwr;
    logic [4:0] wr, rs, rt;
    logic       urt, acc, rdy, br;
  } vin_t;

  typedef struct {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic        me;
    logic        bpcw;
    logic        bme;
  } vexp_t;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEWrite, MEWBWrite}
  localparam logic [5:0] DEF = 6'b110011;
  localparam logic [5:0] RST = 6'b001100;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] STL = 6'b000111;
  localparam logic [5:0] BR  = 6'b111111;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  IDRs = '0, IDRt = '0, EXWriteReg = '0;
  logic        IDUsesRt = 0, EXMemRead = 0, EXRegWrite = 0;
  logic        MEAccess = 0, DMReady = 1, BranchTaken = 0;

  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEWrite, MEWBWrite;
  logic [1:0]  State;
  logic [15:0] StallCount;
  logic        MemError;

  logic        b_PCWrite, b_IFIDWrite, b_IFIDFlush, b_IDEXFlush, b_EXMEWrite, b_MEWBWrite;
  logic [1:0]  b_State;
  logic [15:0] b_StallCount;
  logic        b_MemError;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  vexp_t exp_q[$];
  vexp_t e;

  always #5 clk = ~clk;

  hazard_stall_controller #(.LOAD_STALL_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(16)) dut (
    .Clk(clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXWriteReg(EXWriteReg),
    .MEAccess(MEAccess), .DMReady(DMReady), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .EXMEWrite(EXMEWrite), .MEWBWrite(MEWBWrite),
    .State(State), .StallCount(StallCount), .MemError(MemError)
  );

  hazard_stall_controller dutb (
    .Clk(clk), .Reset(Reset), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
    .EXMemRead(EXMemRead), .EXRegWrite(EXRegWrite), .EXWriteReg(EXWriteReg),
    .MEAccess(MEAccess), .DMReady(DMReady), .BranchTaken(BranchTaken),
    .PCWrite(b_PCWrite), .IFIDWrite(b_IFIDWrite), .IFIDFlush(b_IFIDFlush),
    .IDEXFlush(b_IDEXFlush), .EXMEWrite(b_EXMEWrite), .MEWBWrite(b_MEWBWrite),
    .State(b_State), .StallCount(b_StallCount), .MemError(b_MemError)
  );

  function automatic vin_t vi(input bit rst, input bit mrd, input bit rwr,
                              input logic [4:0] wr, input logic [4:0] rs,
                              input logic [4:0] rt, input bit urt, input bit acc,
                              input bit rdy, input bit br);
    vin_t v;
    v.rst = rst; v.mrd = mrd; v.rwr = rwr; v.wr = wr; v.rs = rs; v.rt = rt;
    v.urt = urt; v.acc = acc; v.rdy = rdy; v.br = br;
    return v;
  endfunction

  function automatic vexp_t ve(input logic [5:0] ctl, input int st, input int sc,
                               input bit me, input bit bpcw, input bit bme);
    vexp_t x;
    x.ctl = ctl; x.st = 2'(st); x.sc = 16'(sc); x.me = me; x.bpcw = bpcw; x.bme = bme;
    return x;
  endfunction

  task automatic step(input vin_t v, input vexp_t x);
    @(posedge clk);
    #1;
    Reset = v.rst; EXMemRead = v.mrd; EXRegWrite = v.rwr; EXWriteReg = v.wr;
    IDRs = v.rs; IDRt = v.rt; IDUsesRt = v.urt; MEAccess = v.acc;
    DMReady = v.rdy; BranchTaken = v.br;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctrl",       32'({PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEWrite, MEWBWrite}), 32'(e.ctl));
      chk("state",      32'(State), 32'(e.st));
      chk("stallcount", 32'(StallCount), 32'(e.sc));
      chk("memerror",   32'(MemError), 32'(e.me));
      chk("b_pcwrite",  32'(b_PCWrite), 32'(e.bpcw));
      chk("b_memerror", 32'(b_MemError), 32'(e.bme));
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vin_t IDLE, LU, WAIT, REL;
    IDLE = vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    LU   = vi(0, 1, 1, 8, 8, 0, 0, 0, 1, 0);
    WAIT = vi(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    REL  = vi(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    // Reset
    for (int i = 0; i < 3; i++) step(vi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ve(RST, 0, 0, 0, 0, 0));
    step(IDLE, ve(DEF, 0, 0, 0, 1, 0));
    // Load-use on rs: two stall cycles, 0->1->0
    step(LU,   ve(STL, 0, 0, 0, 0, 0));
    step(IDLE, ve(STL, 1, 1, 0, 1, 0));
    step(IDLE, ve(DEF, 0, 2, 0, 1, 0));
    // Zero register, rt unused, rt used, no RegWrite
    step(vi(0, 1, 1, 0, 0, 0, 0, 0, 1, 0), ve(DEF, 0, 2, 0, 1, 0));
    step(vi(0, 1, 1, 9, 3, 9, 0, 0, 1, 0), ve(DEF, 0, 2, 0, 1, 0));
    step(vi(0, 1, 1, 9, 3, 9, 1, 0, 1, 0), ve(STL, 0, 2, 0, 0, 0));
    step(IDLE, ve(STL, 1, 3, 0, 1, 0));
    step(IDLE, ve(DEF, 0, 4, 0, 1, 0));
    step(vi(0, 1, 0, 8, 8, 0, 0, 0, 1, 0), ve(DEF, 0, 4, 0, 1, 0));
    // Short DM wait: WaitCnt stays below 3, no error
    step(WAIT, ve(FRZ, 0, 4, 0, 0, 0));
    step(WAIT, ve(FRZ, 2, 5, 0, 0, 0));
    step(WAIT, ve(FRZ, 2, 6, 0, 0, 0));
    step(REL,  ve(DEF, 2, 7, 0, 1, 0));
    step(IDLE, ve(DEF, 0, 7, 0, 1, 0));
    // Five-cycle DM wait: timeout at WaitCnt==3, sticky afterwards
    step(WAIT, ve(FRZ, 0, 7, 0, 0, 0));
    step(WAIT, ve(FRZ, 2, 8, 0, 0, 0));
    step(WAIT, ve(FRZ, 2, 9, 0, 0, 0));
    step(WAIT, ve(FRZ, 2, 10, 0, 0, 0));
    step(WAIT, ve(FRZ, 2, 11, 1, 0, 0));
    step(REL,  ve(DEF, 2, 12, 1, 1, 0));
    step(IDLE, ve(DEF, 0, 12, 1, 1, 0));
    // Load-use and branch together: branch wins
    step(vi(0, 1, 1, 8, 8, 0, 0, 0, 1, 1), ve(BR, 0, 12, 1, 1, 0));
    step(IDLE, ve(DEF, 0, 12, 1, 1, 0));
    // Branch cancels pending LOADUSE
    step(LU,   ve(STL, 0, 12, 1, 0, 0));
    step(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ve(BR, 1, 13, 1, 1, 0));
    step(IDLE, ve(DEF, 0, 13, 1, 1, 0));
    // Freeze inside LOADUSE: LoadCnt held, release cycle is the last stall
    step(LU,   ve(STL, 0, 13, 1, 0, 0));
    step(WAIT, ve(FRZ, 1, 14, 1, 0, 0));
    step(WAIT, ve(FRZ, 2, 15, 1, 0, 0));
    step(WAIT, ve(FRZ, 2, 16, 1, 0, 0));
    step(REL,  ve(STL, 2, 17, 1, 1, 0));
    step(IDLE, ve(DEF, 0, 18, 1, 1, 0));
    // Reset clears the sticky flag and counter
    step(vi(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), ve(RST, 0, 18, 1, 0, 0));
    step(IDLE, ve(DEF, 0, 0, 0, 1, 0));
    // Reset in the middle of a wait aborts it
    step(WAIT, ve(FRZ, 0, 0, 0, 0, 0));
    step(vi(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), ve(RST, 2, 1, 0, 0, 0));
    step(IDLE, ve(DEF, 0, 0, 0, 1, 0));

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
